// File: rtl/vram_port_arbiter.sv
// Shares one synchronous single-port VRAM between fixed-priority pixel fetches
// and a CPU req/ack master with a buffered write path and an ordered read path.
module vram_port_arbiter #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pixel_clk,
   input  logic [ADDR_WIDTH-1:0] clk_read_addr,
   output logic [DATA_WIDTH-1:0] clk_read_data,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_ack,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  fifo_full,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, DRAIN, ISSUE, CAPTURE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  fifo_full_q;
   logic                  cpu_ack_q, cpu_ack_d;
   logic                  pix_pend_q;
   logic [DATA_WIDTH-1:0] clk_read_data_q, cpu_rdata_q;
   logic [ADDR_WIDTH-1:0] last_addr_q;
   logic [DATA_WIDTH-1:0] last_wdata_q;
   logic                  fifo_empty, push, pop, rd_issue;

   assign fifo_empty = (count_q == '0);
   assign pop        = !pixel_clk && !fifo_empty;
   // An ack in flight means the master has not yet seen completion of its current request.
   assign push       = cpu_req && cpu_we && !fifo_full_q && !cpu_ack_q && (state_q == IDLE);
   assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
   assign cpu_ack_d  = push || (state_q == CAPTURE);

   always_comb begin
      state_d  = state_q;
      rd_issue = 1'b0;
      case (state_q)
         IDLE:    if (cpu_req && !cpu_we && !cpu_ack_q) state_d = DRAIN;
         DRAIN:   if (fifo_empty) state_d = ISSUE;
         ISSUE: begin
            if (!pixel_clk && fifo_empty) begin
               rd_issue = 1'b1;
               state_d  = CAPTURE;
            end
         end
         CAPTURE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Unused slots replay the previous address/data so the RAM pins stay quiet.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = last_addr_q;
      mem_wdata = last_wdata_q;
      if (!rst) begin
         if (pixel_clk) begin
            mem_addr = clk_read_addr;
         end else if (pop) begin
            mem_we    = 1'b1;
            mem_addr  = fifo_addr_q[rd_ptr_q];
            mem_wdata = fifo_data_q[rd_ptr_q];
         end else if (rd_issue) begin
            mem_addr = cpu_addr;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         fifo_full_q     <= 1'b0;
         cpu_ack_q       <= 1'b0;
         pix_pend_q      <= 1'b0;
         clk_read_data_q <= '0;
         cpu_rdata_q     <= '0;
         last_addr_q     <= '0;
         last_wdata_q    <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         fifo_full_q <= (count_d == CNT_W'(FIFO_DEPTH));
         cpu_ack_q   <= cpu_ack_d;
         pix_pend_q  <= pixel_clk;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (pix_pend_q) clk_read_data_q <= mem_rdata;
         if (state_q == CAPTURE) cpu_rdata_q <= mem_rdata;
         last_addr_q  <= mem_addr;
         last_wdata_q <= mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= cpu_addr;
         fifo_data_q[wr_ptr_q] <= cpu_wdata;
      end
   end

   assign clk_read_data = clk_read_data_q;
   assign cpu_ack       = cpu_ack_q;
   assign cpu_rdata     = cpu_rdata_q;
   assign fifo_full     = fifo_full_q;
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: VRAM model, transaction-level scoreboard checked
// every cycle, and directed scenarios with literal expectations.
module tb_vram_port_arbiter;
   localparam int AW = 15;
   localparam int DW = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pixel_clk = 1'b0;
   logic [AW-1:0] clk_read_addr = '0;
   logic [DW-1:0] clk_read_data;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;
   logic          fifo_full;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic [DW-1:0] mem_rdata;

   logic [DW-1:0] vram [0:(1<<AW)-1];
   logic          pre_en = 1'b0;
   logic [AW-1:0] pre_addr = '0;
   logic [DW-1:0] pre_data = '0;

   int n_chk = 0;
   int n_fail = 0;
   int pix_mode = 0;   // 0: low, 1: high, 2: alternate

   vram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .pixel_clk(pixel_clk),
      .clk_read_addr(clk_read_addr), .clk_read_data(clk_read_data),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .fifo_full(fifo_full),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM, read-before-write, one cycle read latency.
   always @(posedge clk) begin
      if (pre_en) vram[pre_addr] <= pre_data;
      else if (mem_we) vram[mem_addr] <= mem_wdata;
      mem_rdata <= vram[mem_addr];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: acked writes not yet seen on the RAM port, in order; pixel pipeline of expected data.
   logic [AW+DW-1:0] wq [$];
   logic             s1_v = 1'b0, s2_v = 1'b0;
   logic [DW-1:0]    s1_d = '0, s2_d = '0, exp_pix = '0;
   logic             req_prev = 1'b0, ack_prev = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         chk("reset_outputs", {clk_read_data, cpu_ack, cpu_rdata, fifo_full, mem_addr, mem_wdata, mem_we}, '0);
         wq.delete();
         s1_v = 1'b0; s2_v = 1'b0; exp_pix = '0;
      end else begin
         if (cpu_ack) begin
            chk("ack_after_req", {63'd0, req_prev}, 64'd1);
            chk("ack_one_cycle", {63'd0, ack_prev}, 64'd0);
            if (cpu_we) wq.push_back({cpu_addr, cpu_wdata});
            else begin
               chk("read_after_write", wq.size(), 0);
               chk("cpu_rdata", cpu_rdata, vram[cpu_addr]);
            end
         end
         chk("fifo_full", {63'd0, fifo_full}, {63'd0, wq.size() == DEPTH});
         if (pixel_clk) begin
            chk("tick_no_we", {63'd0, mem_we}, 64'd0);
            chk("tick_addr", mem_addr, clk_read_addr);
         end
         if (mem_we) begin
            if (wq.size() == 0) chk("unexpected_write", {mem_addr, mem_wdata, 1'b1}, '0);
            else chk("write_order", {mem_addr, mem_wdata}, wq.pop_front());
         end
         if (s2_v) exp_pix = s2_d;
         chk("pixel_data", clk_read_data, exp_pix);
         s2_v = s1_v; s2_d = s1_d;
         s1_v = pixel_clk; s1_d = vram[clk_read_addr];
      end
      req_prev = cpu_req;
      ack_prev = cpu_ack;
   end

   task automatic cyc();
      @(posedge clk); #1;
      case (pix_mode)
         0: pixel_clk = 1'b0;
         1: pixel_clk = 1'b1;
         default: pixel_clk = ~pixel_clk;
      endcase
   endtask

   task automatic cpu_start(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
   endtask

   task automatic wait_ack(input int maxc, output bit got, output int n);
      got = 1'b0; n = 0;
      while (!got && n < maxc) begin
         cyc(); n++;
         if (cpu_ack) got = 1'b1;
      end
      if (got) begin
         cpu_req = 1'b0;
         cyc();
      end
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit got; int n;
      cpu_start(1'b1, a, d);
      wait_ack(20, got, n);
      chk("write_acked", {63'd0, got}, 64'd1);
      cpu_req = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
      bit got; int n;
      cpu_start(1'b0, a, '0);
      wait_ack(30, got, n);
      chk("read_acked", {63'd0, got}, 64'd1);
      chk("read_value", cpu_rdata, exp);
      cpu_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      bit got; int n;
      logic [DW-1:0] pre0, pre1;
      // Preload while in reset.
      cyc();
      pre_en = 1'b1; pre_addr = 15'h0100; pre_data = 8'hA5; cyc();
      pre_addr = 15'h0400; pre_data = 8'h3C; cyc();
      pre_en = 1'b0; cyc();
      rst = 1'b0;
      cyc();
      chk("init_outputs", {clk_read_data, cpu_ack, cpu_rdata, fifo_full, mem_we}, '0);

      // Pixel fetch with ticks every other cycle.
      clk_read_addr = 15'h0100;
      pix_mode = 2;
      cyc();
      while (!pixel_clk) cyc();
      cyc(); cyc();
      chk("pixel_A5", clk_read_data, 8'hA5);

      // Single write in a free slot, then readback.
      while (pixel_clk) cyc();
      cpu_start(1'b1, 15'h1234, 8'h5A);
      wait_ack(10, got, n);
      chk("wr_ack", {63'd0, got}, 64'd1);
      chk("wr_ack_latency", n, 1);
      repeat (3) cyc();
      chk("vram_1234", vram[15'h1234], 8'h5A);
      do_read(15'h1234, 8'h5A);

      // Fill the buffer with pixel slots hogging the RAM.
      pix_mode = 1;
      cyc();
      for (int i = 0; i < 4; i++) do_write(15'h0200 + 15'(i), 8'h30 + 8'(i));
      chk("full_after_4", {63'd0, fifo_full}, 64'd1);
      cpu_start(1'b1, 15'h0204, 8'h34);
      wait_ack(6, got, n);
      chk("fifth_stalled", {63'd0, got}, 64'd0);
      pix_mode = 0; pixel_clk = 1'b0;
      wait_ack(20, got, n);
      chk("fifth_acked", {63'd0, got}, 64'd1);
      repeat (3) cyc();
      for (int i = 0; i < 5; i++) chk("drain_vram", vram[15'h0200 + 15'(i)], 8'h30 + 8'(i));
      chk("empty_after_drain", {63'd0, fifo_full}, 64'd0);

      // Read right behind a write sees the new data.
      pix_mode = 2;
      do_write(15'h0010, 8'h11);
      do_read(15'h0010, 8'h11);

      // Reset discards buffered writes.
      pix_mode = 1;
      cyc();
      pre0 = vram[15'h0300]; pre1 = vram[15'h0301];
      do_write(15'h0300, 8'h77);
      do_write(15'h0301, 8'h88);
      rst = 1'b1; #1;
      chk("rst_fifo_full", {63'd0, fifo_full}, 64'd0);
      chk("rst_ack", {63'd0, cpu_ack}, 64'd0);
      chk("rst_pixel_data", clk_read_data, '0);
      chk("rst_cpu_rdata", cpu_rdata, '0);
      cyc();
      rst = 1'b0;
      pix_mode = 0;
      repeat (8) cyc();
      chk("vram_0300_kept", vram[15'h0300], pre0);
      chk("vram_0301_kept", vram[15'h0301], pre1);

      // Read across alternating tick/free slots.
      pix_mode = 2;
      clk_read_addr = 15'h0100;
      repeat (2) cyc();
      do_read(15'h0400, 8'h3C);
      repeat (4) cyc();
      chk("pixel_after_read", clk_read_data, 8'hA5);

      repeat (3) cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
